// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution sequencer.
//   state_t   - sequencer FSM encoding (3 bits)
//   MODE_*    - layer mode select values for cfg_mode
//   tag_t     - beat tag carried alongside the multiplier pipeline
package conv_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic MODE_CONV = 1'b0;
   localparam logic MODE_DW   = 1'b1;

   // valid: a beat was issued; first/last: beat opens/closes a pixel's ic sweep
   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } tag_t;

endpackage

// File: rtl/conv_tag_pipe.sv
// conv_tag_pipe: fixed-depth shift register carrying beat tags so they
// emerge in step with the multiplier output.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset, empties the pipe
//   flush  - synchronous clear, drops every tag in flight
//   tag_i  - tag of the beat issued this cycle
//   tag_o  - tag of the beat issued DEPTH cycles ago
module conv_tag_pipe
   import conv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  tag_t tag_i,
   output tag_t tag_o
);

   tag_t stage_q [DEPTH];

   // Shift one stage per cycle; flush has priority over new tags
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= tag_i;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: convolution sequencer. Walks output-channel groups, output
// pixels and input-channel groups (innermost) for one layer, issuing one MAC
// beat per accepted feature word, and aligns accumulator controls with the
// multiplier pipeline.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   start, abort                - launch (IDLE only) / stop current layer
//   cfg_mode                    - 0 standard conv, 1 depthwise
//   cfg_ic_last/oc_last/px_last - loop bounds (count minus 1)
//   cfg_scale                   - requantisation shift, latched at LOAD
//   feat_valid / feat_ready     - feature beat handshake (ready = issue)
//   feat_addr, weight_addr      - addresses of the beat being issued
//   adder_rst, acc_last         - accumulator first/last-beat controls
//   scale_out                   - latched scale
//   busy, done, state_rst       - status back to the top-level FSM
module conv_seq_ctrl
   import conv_pkg::*;
#(
   parameter int unsigned MAC_IN_NUM          = 9,
   parameter int unsigned MAC_OUT_NUM         = 18,
   parameter int unsigned CNT_WIDTH           = 10,
   parameter int unsigned ADDR_WIDTH          = 16,
   parameter int unsigned SCALE_WIDTH         = 4,
   parameter int unsigned MULT_PIPELINE_STAGE = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   cfg_mode,
   input  logic [CNT_WIDTH-1:0]   cfg_ic_last,
   input  logic [CNT_WIDTH-1:0]   cfg_oc_last,
   input  logic [CNT_WIDTH-1:0]   cfg_px_last,
   input  logic [SCALE_WIDTH-1:0] cfg_scale,
   input  logic                   feat_valid,
   output logic                   feat_ready,
   output logic [ADDR_WIDTH-1:0]  feat_addr,
   output logic [ADDR_WIDTH-1:0]  weight_addr,
   output logic                   adder_rst,
   output logic                   acc_last,
   output logic [SCALE_WIDTH-1:0] scale_out,
   output logic                   busy,
   output logic                   done,
   output logic                   state_rst
);

   localparam int unsigned DRAIN_W =
      (MULT_PIPELINE_STAGE > 1) ? $clog2(MULT_PIPELINE_STAGE) : 1;
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MULT_PIPELINE_STAGE - 1);
   // A degenerate MAC array geometry never issues beats
   localparam logic GEOM_OK = (MAC_IN_NUM > 0) && (MAC_OUT_NUM > 0);

   state_t                   state_q;
   logic [DRAIN_W-1:0]       drain_cnt_q;
   logic                     aborted_q;
   logic [CNT_WIDTH-1:0]     ic_last_q, px_last_q, oc_last_q;
   logic [ADDR_WIDTH-1:0]    stride_q;
   logic [SCALE_WIDTH-1:0]   scale_q;

   logic [CNT_WIDTH-1:0]     ic_q, px_q, oc_q;
   logic [CNT_WIDTH-1:0]     ic_d, px_d, oc_d;
   logic [ADDR_WIDTH-1:0]    feat_base_q, wt_base_q;
   logic [ADDR_WIDTH-1:0]    feat_base_d, wt_base_d;

   logic                     issue;
   logic                     abort_take;
   logic                     ic_wrap, px_wrap, oc_wrap;
   logic                     last_beat;
   logic [CNT_WIDTH-1:0]     ic_last_eff;
   tag_t                     tag_in, tag_out;

   // Depthwise layers have a single ic group per output channel
   assign ic_last_eff = (cfg_mode == MODE_DW) ? '0 : cfg_ic_last;

   assign issue      = (state_q == S_RUN) && feat_valid && GEOM_OK;
   assign abort_take = abort && ((state_q == S_LOAD) || (state_q == S_RUN) ||
                                 (state_q == S_DRAIN));

   assign ic_wrap   = (ic_q == ic_last_q);
   assign px_wrap   = (px_q == px_last_q);
   assign oc_wrap   = (oc_q == oc_last_q);
   assign last_beat = issue && ic_wrap && px_wrap && oc_wrap;

   // Nested loop counters with running address bases (stride = ic_last+1)
   always_comb begin
      ic_d        = ic_q;
      px_d        = px_q;
      oc_d        = oc_q;
      feat_base_d = feat_base_q;
      wt_base_d   = wt_base_q;
      if ((state_q != S_RUN) || abort_take) begin
         ic_d        = '0;
         px_d        = '0;
         oc_d        = '0;
         feat_base_d = '0;
         wt_base_d   = '0;
      end else if (issue) begin
         if (!ic_wrap) begin
            ic_d = ic_q + CNT_WIDTH'(1);
         end else begin
            ic_d = '0;
            if (!px_wrap) begin
               px_d        = px_q + CNT_WIDTH'(1);
               feat_base_d = feat_base_q + stride_q;
            end else begin
               px_d        = '0;
               feat_base_d = '0;
               if (!oc_wrap) begin
                  oc_d      = oc_q + CNT_WIDTH'(1);
                  wt_base_d = wt_base_q + stride_q;
               end else begin
                  oc_d      = '0;
                  wt_base_d = '0;
               end
            end
         end
      end
   end

   // Counter and address-base registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ic_q        <= '0;
         px_q        <= '0;
         oc_q        <= '0;
         feat_base_q <= '0;
         wt_base_q   <= '0;
      end else begin
         ic_q        <= ic_d;
         px_q        <= px_d;
         oc_q        <= oc_d;
         feat_base_q <= feat_base_d;
         wt_base_q   <= wt_base_d;
      end
   end

   // Layer FSM with configuration latch and drain timer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         drain_cnt_q <= '0;
         aborted_q   <= 1'b0;
         ic_last_q   <= '0;
         px_last_q   <= '0;
         oc_last_q   <= '0;
         stride_q    <= '0;
         scale_q     <= '0;
      end else begin
         aborted_q <= 1'b0;
         if (abort_take) begin
            state_q   <= S_IDLE;
            aborted_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               // abort alongside start keeps the block idle
               if (start && !abort) begin
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               ic_last_q <= ic_last_eff;
               px_last_q <= cfg_px_last;
               oc_last_q <= cfg_oc_last;
               stride_q  <= ADDR_WIDTH'(ic_last_eff) + ADDR_WIDTH'(1);
               scale_q   <= cfg_scale;
               if (!abort) begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (!abort && last_beat) begin
                  state_q     <= S_DRAIN;
                  drain_cnt_q <= '0;
               end
            end
            S_DRAIN: begin
               if (!abort) begin
                  if (drain_cnt_q == DRAIN_LAST) begin
                     state_q <= S_DONE;
                  end else begin
                     drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Tags ride beside the multiplier; an abort drops everything in flight
   assign tag_in.valid = issue;
   assign tag_in.first = issue && (ic_q == '0);
   assign tag_in.last  = issue && ic_wrap;

   conv_tag_pipe #(
      .DEPTH (MULT_PIPELINE_STAGE)
   ) u_tag_pipe (
      .clk   (clk),
      .rst   (rst),
      .flush (abort_take),
      .tag_i (tag_in),
      .tag_o (tag_out)
   );

   assign feat_ready  = issue;
   assign feat_addr   = feat_base_q + ADDR_WIDTH'(ic_q);
   assign weight_addr = wt_base_q + ADDR_WIDTH'(ic_q);
   assign adder_rst   = tag_out.valid && tag_out.first;
   assign acc_last    = tag_out.valid && tag_out.last;
   assign scale_out   = scale_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign state_rst   = (state_q == S_DONE) || aborted_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: table of layer launches scored against a beat/tag model,
// plus hand-written reset, abort and start/abort-in-idle sequences.
module tb_conv_seq_ctrl;

   localparam int unsigned CW = 10;
   localparam int unsigned AW = 16;
   localparam int unsigned SW = 4;
   localparam int          P  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          cfg_mode = 1'b0;
   logic [CW-1:0] cfg_ic_last = '0;
   logic [CW-1:0] cfg_oc_last = '0;
   logic [CW-1:0] cfg_px_last = '0;
   logic [SW-1:0] cfg_scale = '0;
   logic          feat_valid = 1'b0;
   logic          feat_ready;
   logic [AW-1:0] feat_addr;
   logic [AW-1:0] weight_addr;
   logic          adder_rst;
   logic          acc_last;
   logic [SW-1:0] scale_out;
   logic          busy;
   logic          done;
   logic          state_rst;

   conv_seq_ctrl #(
      .MAC_IN_NUM          (9),
      .MAC_OUT_NUM         (18),
      .CNT_WIDTH           (CW),
      .ADDR_WIDTH          (AW),
      .SCALE_WIDTH         (SW),
      .MULT_PIPELINE_STAGE (P)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .cfg_mode    (cfg_mode),
      .cfg_ic_last (cfg_ic_last),
      .cfg_oc_last (cfg_oc_last),
      .cfg_px_last (cfg_px_last),
      .cfg_scale   (cfg_scale),
      .feat_valid  (feat_valid),
      .feat_ready  (feat_ready),
      .feat_addr   (feat_addr),
      .weight_addr (weight_addr),
      .adder_rst   (adder_rst),
      .acc_last    (acc_last),
      .scale_out   (scale_out),
      .busy        (busy),
      .done        (done),
      .state_rst   (state_rst)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int feat;
      int wt;
      bit first;
      bit last;
   } beat_t;

   typedef struct {
      int due;
      bit first;
      bit last;
   } tagexp_t;

   typedef struct {
      bit       mode;
      int       ic;
      int       px;
      int       oc;
      bit [3:0] scale;
      bit       alt;
      int       restart_k;
      bit       scale_chg;
      int       exp_done;
   } vec_t;

   beat_t   beat_q[$];
   tagexp_t tag_q[$];
   vec_t    tbl[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: pop expected beats on feat_ready, check tags at their due cycle
   always @(negedge clk) begin
      if (mon_en) begin
         bit    ea;
         bit    el;
         beat_t b;
         ea = 1'b0;
         el = 1'b0;
         if (tag_q.size() > 0 && tag_q[0].due == cyc) begin
            ea = tag_q[0].first;
            el = tag_q[0].last;
            void'(tag_q.pop_front());
         end
         chk("adder_rst", 64'(adder_rst), 64'(ea));
         chk("acc_last", 64'(acc_last), 64'(el));
         if (feat_ready) begin
            if (beat_q.size() == 0) begin
               chk("unexpected_beat", 64'(feat_ready), 64'(0));
            end else begin
               b = beat_q.pop_front();
               chk("feat_addr", 64'(feat_addr), 64'(b.feat));
               chk("weight_addr", 64'(weight_addr), 64'(b.wt));
               tag_q.push_back('{due: cyc + P, first: b.first, last: b.last});
            end
         end
      end
   end

   task automatic push_beats(input bit mode, input int ic, input int px, input int oc);
      int ic_eff;
      ic_eff = mode ? 0 : ic;
      for (int o = 0; o <= oc; o++)
         for (int p = 0; p <= px; p++)
            for (int i = 0; i <= ic_eff; i++)
               beat_q.push_back('{feat: p * (ic_eff + 1) + i,
                                  wt: o * (ic_eff + 1) + i,
                                  first: (i == 0), last: (i == ic_eff)});
   endtask

   task automatic launch(input bit mode, input int ic, input int px, input int oc,
                         input bit [3:0] scale);
      @(posedge clk); #1;
      cfg_mode    = mode;
      cfg_ic_last = CW'(ic);
      cfg_px_last = CW'(px);
      cfg_oc_last = CW'(oc);
      cfg_scale   = scale;
      start       = 1'b1;
      feat_valid  = 1'b0;
   endtask

   task automatic run_layer(input vec_t v);
      int k;
      int done_k;
      push_beats(v.mode, v.ic, v.px, v.oc);
      launch(v.mode, v.ic, v.px, v.oc, v.scale);
      done_k = -1;
      k = 1;
      while (k <= v.exp_done + 20 && done_k < 0) begin
         @(posedge clk); #1;
         start      = (v.restart_k == k);
         feat_valid = v.alt ? (k % 2 == 1) : 1'b1;
         if (v.scale_chg && k == 4) cfg_scale = 4'h3;
         @(negedge clk);
         if (k == 1) chk("busy_load", 64'(busy), 64'(1));
         if (k >= 2) chk("scale_out", 64'(scale_out), 64'(v.scale));
         if (done) begin
            done_k = k;
            chk("state_rst_done", 64'(state_rst), 64'(1));
         end
         k++;
      end
      chk("done_latency", 64'(done_k), 64'(v.exp_done));
      @(posedge clk); #1;
      start      = 1'b0;
      feat_valid = 1'b0;
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'(0));
      chk("busy_idle", 64'(busy), 64'(0));
      chk("beats_left", 64'(beat_q.size()), 64'(0));
      chk("tags_left", 64'(tag_q.size()), 64'(0));
      beat_q.delete();
      tag_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      //             mode  ic px oc scale alt rst_k chg done
      tbl[0] = '{1'b0, 2, 1, 0, 4'h5, 1'b0, 0, 1'b0, 10};
      tbl[1] = '{1'b1, 5, 2, 1, 4'h7, 1'b0, 0, 1'b0, 10};
      tbl[2] = '{1'b0, 2, 1, 0, 4'h5, 1'b1, 0, 1'b0, 16};
      tbl[3] = '{1'b0, 3, 2, 2, 4'hA, 1'b0, 0, 1'b1, 40};
      tbl[4] = '{1'b0, 0, 3, 1, 4'h3, 1'b0, 0, 1'b0, 12};
      tbl[5] = '{1'b1, 0, 0, 0, 4'h9, 1'b0, 2, 1'b0, 5};
      tbl[6] = '{1'b0, 1, 1, 1, 4'h6, 1'b1, 3, 1'b0, 20};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs",
          64'({busy, done, state_rst, feat_ready, adder_rst, acc_last,
               feat_addr, weight_addr, scale_out}), 64'(0));
      @(posedge clk); #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      for (int r = 0; r < 5; r++) run_layer(tbl[r]);

      // Reset mid-DRAIN: everything back to zero on the next edge
      push_beats(1'b0, 2, 1, 0);
      launch(1'b0, 2, 1, 0, 4'hC);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         start      = 1'b0;
         feat_valid = 1'b1;
         rst        = (k == 8);
         @(negedge clk);
      end
      chk("busy_drain", 64'(busy), 64'(1));
      chk("beats_before_rst", 64'(beat_q.size()), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      tag_q.delete();
      @(negedge clk);
      chk("post_rst_outputs",
          64'({busy, done, state_rst, feat_ready, adder_rst, acc_last,
               feat_addr, weight_addr, scale_out}), 64'(0));
      feat_valid = 1'b0;

      for (int r = 5; r < 7; r++) run_layer(tbl[r]);

      // Abort on the third RUN cycle
      push_beats(1'b0, 2, 1, 0);
      launch(1'b0, 2, 1, 0, 4'h4);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         start      = 1'b0;
         feat_valid = 1'b1;
         abort      = (k == 4);
         @(negedge clk);
      end
      chk("busy_before_abort", 64'(busy), 64'(1));
      @(posedge clk); #1;
      abort = 1'b0;
      beat_q.delete();
      tag_q.delete();
      @(negedge clk);
      chk("abort_idle", 64'(busy), 64'(0));
      chk("abort_state_rst", 64'(state_rst), 64'(1));
      chk("abort_no_done", 64'(done), 64'(0));
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("abort_state_rst_once", 64'(state_rst), 64'(0));
         chk("abort_done_low", 64'(done), 64'(0));
      end
      feat_valid = 1'b0;

      // start together with abort in IDLE: abort wins
      @(posedge clk); #1;
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk("start_abort_idle", 64'(busy), 64'(0));
      chk("start_abort_no_rst", 64'(state_rst), 64'(0));
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Parametrised convolution sequencer for the ConvUnit datapath. It accepts a per-layer configuration and walks output-channel groups, output pixels and input-channel groups in nested order, issuing one MAC beat per accepted feature word. A delay line matched to the multiplier pipeline aligns `adder_rst`, `acc_last` and `scale_out` with the accumulator. It adds a depthwise mode, input stall and abort, and a done/`state_rst` handshake back to the top-level state machine.

## Interface
- `MAC_IN_NUM`, 9, MAC inputs per beat (array rows)
- `MAC_OUT_NUM`, 18, MAC outputs per beat (output channels per group)
- `CNT_WIDTH`, 10, width of every loop counter and config field
- `ADDR_WIDTH`, 16, weight / feature address width
- `SCALE_WIDTH`, 4, requantisation shift width
- `MULT_PIPELINE_STAGE`, 2, multiplier latency in cycles; must be ≥1

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle launch request; honoured only in IDLE
- `abort`  in  1  stop the current layer; honoured in LOAD, RUN and DRAIN
- `cfg_mode`  in  1  0 = standard conv, 1 = depthwise
- `cfg_ic_last`  in  CNT_WIDTH  number of input-channel groups minus 1
- `cfg_oc_last`  in  CNT_WIDTH  number of output-channel groups minus 1
- `cfg_px_last`  in  CNT_WIDTH  number of output pixels minus 1
- `cfg_scale`  in  SCALE_WIDTH  layer requantisation shift
- `feat_valid`  in  1  feature word available for this beat
- `feat_ready`  out  1  beat consumed this cycle (= `issue`)
- `feat_addr`  out  ADDR_WIDTH  feature address: px·(ic_last+1)+ic
- `weight_addr`  out  ADDR_WIDTH  weight address: oc·(ic_last+1)+ic; depthwise: oc
- `adder_rst`  out  1  accumulator clears and loads, aligned to the first ic beat
- `acc_last`  out  1  final ic beat of a pixel, aligned to the accumulator
- `scale_out`  out  SCALE_WIDTH  latched `cfg_scale`
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse when a layer ends normally
- `state_rst`  out  1  one-cycle pulse with `done` or after an abort, to the top FSM

## Operation
- FSM states: IDLE → LOAD → RUN → DRAIN → DONE → IDLE.
- IDLE: `start` moves to LOAD.
- LOAD: latches all `cfg_*` inputs. In depthwise mode the latched ic_last is forced to 0. Counters clear. Always moves to RUN next cycle.
- RUN: `issue = feat_valid`. On `issue`, ic increments. When ic wraps, px increments. When px wraps, oc increments.
- RUN ends on the issue where ic, px and oc are all at their last values; the next state is DRAIN.
- Addresses use running base registers, with no multipliers. `feat_addr` and `weight_addr` are combinational from the counters and bases, and are valid whenever `feat_ready` is high.
- Delay line: `MULT_PIPELINE_STAGE` stages carry {valid, first = (ic==0), last = (ic==ic_last)}.
  - `adder_rst` = stage-out valid & first.
  - `acc_last` = stage-out valid & last.
  - When ic_last = 0, both are high on the same cycle.
- DRAIN: holds for `MULT_PIPELINE_STAGE` cycles so the delay line empties, then moves to DONE.
- DONE: `done` = `state_rst` = 1 for one cycle, then IDLE.
- Abort: from LOAD, RUN or DRAIN, go to IDLE on the next edge. The delay line is flushed, so no further `adder_rst` or `acc_last` is produced. `state_rst` pulses once and `done` stays low.
- `start` outside IDLE is ignored. If `start` and `abort` arrive together in IDLE, `abort` wins.

## Timing
- Reset values: state IDLE, every counter 0, delay line empty. All outputs are 0, including `scale_out` and both addresses.
- `start` at cycle t: `busy` rises at t+1 (LOAD), and the first possible `feat_ready` is at t+2.
- A beat issued at cycle n produces its `adder_rst` / `acc_last` at cycle n+`MULT_PIPELINE_STAGE`.
- With no stalls, a layer lasts 1 + N + P + 1 cycles from LOAD to DONE inclusive, where N = (ic+1)(px+1)(oc+1) and P = `MULT_PIPELINE_STAGE`.
- A `feat_valid` low cycle freezes the counters and inserts a bubble (valid=0) into the delay line.
- `scale_out` is stable from LOAD until the next LOAD.
- `rst` during any state returns the block to its reset values on the next edge.

## Structure
- A shared package `conv_pkg` holds the FSM state encoding (3 bits) and the mode constants `MODE_CONV` and `MODE_DW`.
- One sub-module, `conv_tag_pipe`: a parametrised shift register of depth `MULT_PIPELINE_STAGE` with a synchronous flush input. It carries the {valid, first, last} tags.
- Counters, address bases and the FSM live in the top level.

## Test plan
- Standard conv, ic_last=2, px_last=1, oc_last=0, P=2, `feat_valid` tied high:
  - `feat_addr` sequence is 0..5 and `weight_addr` is 0,1,2,0,1,2.
  - `adder_rst` appears at issue cycles 0 and 3 plus 2; `acc_last` at issue cycles 2 and 5 plus 2.
  - `done` occurs 10 cycles after `start`.
- Depthwise, cfg_ic_last=5 (forced to 0), px_last=2, oc_last=1: `adder_rst` and `acc_last` are high together on all 6 beats, and `weight_addr` is 0,0,0,1,1,1.
- `feat_valid` low on alternating cycles: exactly the same address and tag sequences as the first scenario, with valid=0 bubbles, and `done` is delayed by the number of stall cycles.
- `abort` on the third RUN cycle: IDLE on the next edge, one `state_rst` pulse, no `done`, and no `adder_rst` or `acc_last` after the abort edge.
- `rst` asserted mid-DRAIN, then `start` during RUN: all outputs are 0 after reset, and the second `start` is ignored (layer length unchanged).
- `cfg_scale`=4'hA at launch, changed to 4'h3 during RUN: `scale_out` stays 4'hA until the next LOAD.
